// File: rtl/polyvec_rd_seq.sv
// Read sequencer for one polyvec RAM instance: sweeps a contiguous row range
// across every bank in lockstep, absorbs the fixed RAM read latency in a small
// credit-controlled FIFO and streams each row out as one wide word.
`ifndef COMMON_BRAM_DELAY
`define COMMON_BRAM_DELAY 2
`endif

module polyvec_rd_seq #(
  parameter int COE_WIDTH         = 39,
  parameter int ADDR_WIDTH        = 9,
  parameter int NUM_POLY          = 8,
  parameter int NUM_BASE_BANK     = 8,
  parameter int COMMON_BRAM_DELAY = `COMMON_BRAM_DELAY
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [ADDR_WIDTH-1:0]                        base_addr,
  input  logic [ADDR_WIDTH:0]                          num_rows,
  output logic                                         busy,
  output logic                                         done,
  output logic [ADDR_WIDTH*NUM_POLY*NUM_BASE_BANK-1:0] addrb,
  input  logic [COE_WIDTH*NUM_POLY*NUM_BASE_BANK-1:0]  doutb,
  output logic [COE_WIDTH*NUM_POLY*NUM_BASE_BANK-1:0]  m_data,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic                                         m_last
);

  localparam int NB    = NUM_POLY * NUM_BASE_BANK;
  localparam int W     = COE_WIDTH * NB;
  localparam int F     = COMMON_BRAM_DELAY + 2;
  // One stage for the registered address plus the RAM latency: the tag at the
  // far end lines up exactly with the cycle the read data sits on doutb.
  localparam int PD    = COMMON_BRAM_DELAY + 1;
  localparam int PTR_W = (F > 1) ? $clog2(F) : 1;
  localparam int CNT_W = $clog2(F + 1) + 1;
  localparam logic [ADDR_WIDTH:0] MAX_ROWS = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_reg;
  logic [ADDR_WIDTH-1:0] row_reg;
  logic [ADDR_WIDTH:0]   rows_left_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [PD-1:0]         pipe_reg;
  logic [PD-1:0]         last_pipe_reg;
  logic                  done_reg;

  logic [W:0]            fifo_mem [F];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  logic [ADDR_WIDTH:0]   num_clip;
  logic [CNT_W-1:0]      inflight;
  logic                  pop;
  logic                  wr_en;
  logic                  credit_ok;
  logic                  issue_start;
  logic                  issue_run;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_row;
  logic [ADDR_WIDTH:0]   issue_left;
  logic                  issue_last;
  logic [W:0]            head;

  assign num_clip = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;

  // Count reads that have been issued but not yet landed in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PD; i++) begin
      inflight = inflight + CNT_W'(pipe_reg[i]);
    end
  end

  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid & m_ready;
  assign wr_en   = pipe_reg[PD-1];
  // An entry popped this cycle frees its slot in time for a new issue, which
  // is what keeps the stream bubble-free while m_ready stays high.
  assign credit_ok = (fifo_count - CNT_W'(pop) + inflight) < CNT_W'(F);

  // The first row is issued on the same edge that accepts start.
  assign issue_start = (state_reg == S_IDLE) && start && (num_clip != '0);
  assign issue_run   = (state_reg == S_RUN) && credit_ok;
  assign issue       = issue_start | issue_run;
  assign issue_row   = issue_start ? base_addr : row_reg;
  assign issue_left  = issue_start ? num_clip : rows_left_reg;
  assign issue_last  = (issue_left == (ADDR_WIDTH + 1)'(1));

  assign head    = fifo_mem[rd_ptr];
  assign m_data  = m_valid ? head[W-1:0] : '0;
  assign m_last  = m_valid & head[W];
  assign busy    = (state_reg != S_IDLE);
  assign done    = done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_addr
      assign addrb[gi*ADDR_WIDTH +: ADDR_WIDTH] = addr_reg;
    end
  endgenerate

  // Sweep control: state, row pointer, remaining count and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      row_reg       <= '0;
      rows_left_reg <= '0;
      addr_reg      <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (num_clip == '0) begin
              done_reg <= 1'b1;
            end else begin
              state_reg <= issue_last ? S_DRAIN : S_RUN;
            end
          end
        end
        S_RUN: begin
          if (issue && issue_last) begin
            state_reg <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && head[W]) begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
      if (issue) begin
        addr_reg      <= issue_row;
        row_reg       <= issue_row + 1'b1;
        rows_left_reg <= issue_left - 1'b1;
      end
    end
  end

  // Read tags track each issued row (and its last flag) through the RAM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_reg      <= '0;
      last_pipe_reg <= '0;
    end else begin
      pipe_reg      <= {pipe_reg[PD-2:0], issue};
      last_pipe_reg <= {last_pipe_reg[PD-2:0], issue & issue_last};
    end
  end

  // FIFO pointers and occupancy; simultaneous write and pop are both honoured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == PTR_W'(F - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(F - 1)) ? '0 : rd_ptr + 1'b1;
      end
      fifo_count <= fifo_count + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  // FIFO storage: RAM data with its last flag; outputs are gated while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr] <= {last_pipe_reg[PD-1], doutb};
    end
  end

endmodule

// File: tb/tb_polyvec_rd_seq.sv
// Directed bench for polyvec_rd_seq with a small 4-bank configuration and a
// latency-2 RAM model whose bank k holds (k<<8)|row at every row.
module tb_polyvec_rd_seq;

  localparam int COE = 39;
  localparam int AW  = 4;
  localparam int NP  = 2;
  localparam int NBB = 2;
  localparam int D   = 2;
  localparam int NB  = NP * NBB;
  localparam int W   = COE * NB;
  localparam int F   = D + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_rows;
  logic          busy;
  logic          done;
  logic [AW*NB-1:0] addrb;
  logic [W-1:0]  doutb;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;
  int cur_base = 0;
  int addr_n = 0;
  bit chk_addr = 1'b0;
  bit chk_stall = 1'b0;
  bit rand_ready = 1'b0;
  bit stall_prev = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  logic [W-1:0] q_data [$];
  bit           q_last [$];
  int           q_cyc  [$];

  logic [AW*NB-1:0] ram_pipe [0:D-1];

  polyvec_rd_seq #(
    .COE_WIDTH(COE), .ADDR_WIDTH(AW), .NUM_POLY(NP),
    .NUM_BASE_BANK(NBB), .COMMON_BRAM_DELAY(D)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .busy(busy), .done(done), .addrb(addrb),
    .doutb(doutb), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [AW*NB-1:0] rep_addr(input int r);
    logic [AW*NB-1:0] a;
    logic [AW-1:0] rr;
    rr = AW'(r % (1 << AW));
    for (int k = 0; k < NB; k++) a[k*AW +: AW] = rr;
    return a;
  endfunction

  function automatic logic [W-1:0] ram_word(input logic [AW*NB-1:0] a);
    logic [W-1:0] w;
    for (int k = 0; k < NB; k++) w[k*COE +: COE] = COE'((k << 8) | int'(a[k*AW +: AW]));
    return w;
  endfunction

  // RAM model: read data appears D cycles after the address.
  always @(posedge clk) begin
    ram_pipe[0] <= addrb;
    for (int i = 1; i < D; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign doutb = ram_word(ram_pipe[D-1]);

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Random backpressure source.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end
  end

  // Stream monitor: records handshakes, checks stall stability and addresses.
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      q_data.push_back(m_data);
      q_last.push_back(m_last);
      q_cyc.push_back(cyc - t0);
    end
    if (chk_stall && stall_prev) begin
      check("stall_valid", m_valid, 1);
      check("stall_data", m_data, prev_data);
      check("stall_last", m_last, prev_last);
    end
    if (chk_stall) check("fifo_bound", dut.fifo_count <= F, 1);
    if (chk_addr && (cyc - t0) >= 1 && (cyc - t0) <= addr_n)
      check("addrb", addrb, rep_addr(cur_base + (cyc - t0) - 1));
    stall_prev <= m_valid && !m_ready;
    prev_data  <= m_data;
    prev_last  <= m_last;
  end

  task automatic sweep(input int base, input int n, input int n_eff, input bit rnd, input int restart_at);
    int done_cyc;
    done_cyc = -1;
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    rand_ready = rnd;
    if (!rnd) m_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(base);
    num_rows = (AW + 1)'(n);
    t0 = cyc;
    cur_base = base;
    addr_n = rnd ? 0 : n_eff;
    chk_addr = 1'b1;
    chk_stall = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if ((cyc - t0) == restart_at) begin
        start = 1'b1;
        base_addr = 4'd9;
        num_rows = 5'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cyc = cyc - t0;
        check("busy_at_done", busy, 0);
        break;
      end
    end
    start = 1'b0;
    chk_addr = 1'b0;
    chk_stall = 1'b0;
    rand_ready = 1'b0;
    m_ready = 1'b1;
    check("done_seen", done_cyc >= 0, 1);
    if (!rnd) check("done_cycle", done_cyc, n_eff + 2 + D);
    check("row_count", q_data.size(), n_eff);
    for (int i = 0; i < n_eff && i < q_data.size(); i++) begin
      check("row_data", q_data[i], ram_word(rep_addr(base + i)));
      check("row_last", q_last[i], i == n_eff - 1);
      if (!rnd) check("row_cycle", q_cyc[i], i + 2 + D);
    end
    $display("sweep base=%0d num_rows=%0d rows_out=%0d done_cycle=%0d", base, n, q_data.size(), done_cyc);
  endtask

  task automatic zero_sweep();
    logic [AW*NB-1:0] a0;
    @(posedge clk);
    #1;
    a0 = addrb;
    start = 1'b1;
    base_addr = 4'd7;
    num_rows = '0;
    t0 = cyc;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("zero_done", done, c == 1);
      check("zero_valid", m_valid, 0);
      check("zero_busy", busy, 0);
      check("zero_addrb", addrb, a0);
      if (c == 1) start = 1'b0;
    end
    $display("sweep base=7 num_rows=0 rows_out=0 done_cycle=1");
  endtask

  task automatic reset_mid();
    bit seen;
    seen = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = '0;
    num_rows = 5'd16;
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (m_valid && m_data[AW-1:0] == 4'd5) seen = 1'b1;
    end
    check("rst_row5_seen", seen, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_valid", m_valid, 0);
    check("rst_mid_last", m_last, 0);
    check("rst_mid_addrb", addrb, 0);
    check("rst_mid_data", m_data, 0);
    @(negedge clk);
    check("rst_hold_valid", m_valid, 0);
    check("rst_hold_busy", busy, 0);
    rst = 1'b0;
    $display("reset asserted mid-sweep at row 5");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_rows = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_addrb", addrb, 0);
    check("rst_data", m_data, 0);
    rst = 1'b0;

    sweep(0, 16, 16, 1'b0, -1);
    sweep(14, 4, 4, 1'b0, -1);
    sweep(0, 16, 16, 1'b1, -1);
    zero_sweep();
    sweep(3, 20, 16, 1'b0, -1);
    sweep(5, 10, 10, 1'b0, 6);
    reset_mid();
    sweep(0, 16, 16, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
